draw_sequencer: RTL
===================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameters: NUM_OBJ, default 8, number of object slots; BG_COLOUR, default 3'b000, erase colour.
REQ-002 clk  in  1  circuit clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 frame_start  in  1  single-cycle request to redraw all slots.
REQ-005 obj_idx  out  3  slot currently addressed by the sequencer.
REQ-006 obj_x, obj_y  in  8, 7  top-left of object at obj_idx, combinational from the object registers.
REQ-007 obj_w, obj_h, obj_c  in  5, 5, 3  size codes and colour of object at obj_idx.
REQ-008 obj_valid  in  1  slot at obj_idx holds a live object.
REQ-009 d_x, d_y, d_w, d_h, d_c  out  8, 7, 5, 5, 3  parameters presented to the downstream draw stage.
REQ-010 d_load_n  out  1  active-low load strobe to the draw stage (wired to its reset input).
REQ-011 d_enable  out  1  enable to the draw stage.
REQ-012 d_done  in  1  completion flag from the draw stage.
REQ-013 plot  out  1  pixel-write strobe to the VGA adapter.
REQ-014 busy  out  1  high from frame acceptance until frame_done.
REQ-015 frame_done  out  1  single-cycle pulse after the last slot completes.

Function
REQ-016 States SHALL be IDLE, SCAN, LOAD, RUN, NEXT; phase bit ph selects ERASE(0) or DRAW(1).
REQ-017 IDLE: frame_start=1 -> SCAN next cycle, obj_idx=0, ph=ERASE, busy=1.
REQ-018 SCAN, ERASE: shadow[obj_idx] valid -> LOAD with shadow coords/sizes and c=BG_COLOUR; else ph=DRAW, stay SCAN.
REQ-019 SCAN, DRAW: obj_valid=1 -> LOAD with obj_* and c=obj_c, shadow[obj_idx] written {obj_x,obj_y,obj_w,obj_h,valid=1}; obj_valid=0 -> shadow valid cleared, go NEXT.
REQ-020 LOAD SHALL last exactly one cycle with d_load_n=0, d_enable=0; d_* stable from LOAD until leaving RUN.
REQ-021 RUN: d_load_n=1, d_enable=1 until d_done=1 sampled; then ERASE -> ph=DRAW, SCAN; DRAW -> NEXT.
REQ-022 plot SHALL equal (state==RUN) & ~d_done.
REQ-023 NEXT: obj_idx==NUM_OBJ-1 -> IDLE, frame_done=1 for one cycle, busy=0; else obj_idx+1, ph=ERASE, SCAN.
REQ-024 obj_w/obj_h SHALL pass to d_w/d_h unmodified; size encoding is owned by the draw stage.
REQ-025 frame_start while busy SHALL set a single pending flag (further requests dropped); pending causes IDLE->SCAN on the cycle after frame_done, then clears.
REQ-026 frame_start coincident with frame_done SHALL set pending.
REQ-027 Shadow write happens at SCAN->LOAD in DRAW phase, so an erase always uses coordinates of the previous frame's draw.

Reset
REQ-028 reset=0 SHALL force IDLE, obj_idx=0, ph=ERASE, pending=0, all shadow valid bits 0, busy=0, frame_done=0, plot=0, d_enable=0, d_load_n=0, d_x..d_c=0.
REQ-029 Reset mid-frame SHALL abandon the frame; no erase of partially drawn objects on the next frame.
REQ-030 First cycle after release: d_load_n=1, state IDLE.

Structure
REQ-031 Shared package draw_pkg SHALL hold the state enum, NUM_OBJ default, BG_COLOUR, and coordinate/size/colour widths.
REQ-032 Shadow table SHALL be a sub-module draw_shadow_table (NUM_OBJ x 26 bits, 1 write, 1 async read, per-entry valid, clear on reset).
REQ-033 Total RTL 120-400 lines; no instantiation of the draw stage inside this block.

Verification
REQ-034 Reset, then frame_start with slot 0 valid (x=10,y=20,w=3,h=3,c=3'b100), others invalid -> no erase, one LOAD, d_x=10,d_y=20,d_c=3'b100, frame_done once after slot 7.
REQ-035 Second frame, slot 0 moved to x=11 -> ERASE pass at x=10,y=20,c=3'b000, then DRAW at x=11,c=3'b100.
REQ-036 Third frame, slot 0 obj_valid=0 -> erase at x=11 only, shadow cleared; fourth frame -> no LOAD.
REQ-037 frame_start pulsed three times during busy -> exactly one extra frame, starting the cycle after frame_done.
REQ-038 Reset asserted during RUN -> d_enable=0, plot=0 immediately; next frame performs no erase.
REQ-039 Bench draw model holding d_done low 50 cycles -> sequencer stays in RUN, plot high throughout, no slot skipped.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw sequencer slice.
package draw_pkg;

  localparam int NUM_OBJ_DEF = 8;
  localparam logic [2:0] BG_COLOUR_DEF = 3'b000;

  localparam int IDX_W = 3;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int S_W   = 5;
  localparam int C_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LOAD,
    ST_RUN,
    ST_NEXT
  } state_e;

  typedef enum logic {
    PH_ERASE = 1'b0,
    PH_DRAW  = 1'b1
  } phase_e;

  // Geometry of one object; the shadow table stores this plus a valid bit.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [S_W-1:0] w;
    logic [S_W-1:0] h;
  } geom_t;

  localparam int SHADOW_W = $bits(geom_t) + 1;

endpackage

// File: rtl/draw_sequencer_if.sv
// Bus between the sequencer, the object registers and the draw stage.
interface draw_sequencer_if;
  import draw_pkg::*;

  logic             frame_start;
  logic [IDX_W-1:0] obj_idx;
  logic [X_W-1:0]   obj_x;
  logic [Y_W-1:0]   obj_y;
  logic [S_W-1:0]   obj_w;
  logic [S_W-1:0]   obj_h;
  logic [C_W-1:0]   obj_c;
  logic             obj_valid;
  logic [X_W-1:0]   d_x;
  logic [Y_W-1:0]   d_y;
  logic [S_W-1:0]   d_w;
  logic [S_W-1:0]   d_h;
  logic [C_W-1:0]   d_c;
  logic             d_load_n;
  logic             d_enable;
  logic             d_done;
  logic             plot;
  logic             busy;
  logic             frame_done;

  // Sequencer side
  modport master (
    input  frame_start, obj_x, obj_y, obj_w, obj_h, obj_c, obj_valid, d_done,
    output obj_idx, d_x, d_y, d_w, d_h, d_c, d_load_n, d_enable, plot, busy,
    frame_done
  );

  // Environment side: object registers, draw stage and frame controller
  modport slave (
    output frame_start, obj_x, obj_y, obj_w, obj_h, obj_c, obj_valid, d_done,
    input  obj_idx, d_x, d_y, d_w, d_h, d_c, d_load_n, d_enable, plot, busy,
    frame_done
  );

endinterface

// File: rtl/draw_shadow_table.sv
// Remembers where each slot was last drawn so the next frame can erase it.
module draw_shadow_table
  import draw_pkg::*;
#(
  parameter int NUM_OBJ = NUM_OBJ_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  geom_t            wgeom,
  input  logic             wvalid,
  input  logic [IDX_W-1:0] raddr,
  output geom_t            rgeom,
  output logic             rvalid
);

  logic [SHADOW_W-1:0] mem_q [NUM_OBJ];
  logic [SHADOW_W-1:0] mem_d [NUM_OBJ];
  logic [SHADOW_W-1:0] rd_word;

  // Single write port; a write with wvalid=0 retires the entry.
  always_comb begin
    mem_d = mem_q;
    if (we && (int'(waddr) < NUM_OBJ)) begin
      mem_d[waddr] = {wvalid, wgeom};
    end
  end

  // Table storage; reset clears every entry, including its valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read; unused addresses read back as empty.
  always_comb begin
    rd_word = '0;
    if (int'(raddr) < NUM_OBJ) begin
      rd_word = mem_q[raddr];
    end
  end

  assign rvalid = rd_word[SHADOW_W-1];
  assign rgeom  = geom_t'(rd_word[SHADOW_W-2:0]);

endmodule

// File: rtl/draw_sequencer.sv
// Walks every object slot per frame, erasing the old image then drawing the new.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int             NUM_OBJ   = NUM_OBJ_DEF,
  parameter logic [C_W-1:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input logic              clk,
  input logic              reset,
  draw_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  phase_e           ph_q, ph_d;
  logic             pending_q, pending_d;
  geom_t            dgeom_q, dgeom_d;
  logic [C_W-1:0]   dc_q, dc_d;

  logic  sh_we;
  logic  sh_wvalid;
  geom_t sh_rgeom;
  logic  sh_rvalid;
  geom_t obj_geom;

  assign obj_geom = {bus.obj_x, bus.obj_y, bus.obj_w, bus.obj_h};

  draw_shadow_table #(
    .NUM_OBJ (NUM_OBJ)
  ) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .we     (sh_we),
    .waddr  (idx_q),
    .wgeom  (obj_geom),
    .wvalid (sh_wvalid),
    .raddr  (idx_q),
    .rgeom  (sh_rgeom),
    .rvalid (sh_rvalid)
  );

  // State register plus the latched draw parameters and request flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ph_q      <= PH_ERASE;
      pending_q <= 1'b0;
      dgeom_q   <= '0;
      dc_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ph_q      <= ph_d;
      pending_q <= pending_d;
      dgeom_q   <= dgeom_d;
      dc_q      <= dc_d;
    end
  end

  // Next-state logic; draw parameters only change on entry to LOAD.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ph_d      = ph_q;
    pending_d = pending_q;
    dgeom_d   = dgeom_q;
    dc_d      = dc_q;
    sh_we     = 1'b0;
    sh_wvalid = 1'b0;

    if ((state_q != ST_IDLE) && bus.frame_start) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start || pending_q) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          ph_d      = PH_ERASE;
          pending_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (ph_q == PH_ERASE) begin
          if (sh_rvalid) begin
            state_d = ST_LOAD;
            dgeom_d = sh_rgeom;
            dc_d    = BG_COLOUR;
          end else begin
            ph_d = PH_DRAW;
          end
        end else begin
          sh_we = 1'b1;
          if (bus.obj_valid) begin
            sh_wvalid = 1'b1;
            state_d   = ST_LOAD;
            dgeom_d   = obj_geom;
            dc_d      = bus.obj_c;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.d_done) begin
          if (ph_q == PH_ERASE) begin
            ph_d    = PH_DRAW;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          ph_d    = PH_ERASE;
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decoded from state; load_n is held low while reset is asserted.
  always_comb begin
    bus.d_load_n   = 1'b1;
    bus.d_enable   = 1'b0;
    bus.plot       = 1'b0;
    bus.frame_done = 1'b0;
    bus.busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_LOAD: bus.d_load_n = 1'b0;
      ST_RUN: begin
        bus.d_enable = 1'b1;
        bus.plot     = ~bus.d_done;
      end
      ST_NEXT: bus.frame_done = (idx_q == LAST_IDX);
      default: ;
    endcase
    if (!reset) begin
      bus.d_load_n = 1'b0;
    end
  end

  assign bus.obj_idx = idx_q;
  assign bus.d_x     = dgeom_q.x;
  assign bus.d_y     = dgeom_q.y;
  assign bus.d_w     = dgeom_q.w;
  assign bus.d_h     = dgeom_q.h;
  assign bus.d_c     = dc_q;

endmodule
